prompt_sequencer: RTL and testbench

Generates, stores and replays the growing pseudo-random prompt sequence for the memory game. It sits directly upstream of the prompt display path: the control FSM requests one new prompt per level (`append`) and a playback (`replay`). The block then emits prompt codes 1–4 (toggle, push, mic, mouse) one at a time at a fixed on/off cadence on `prompt`, which drives the LEDR prompt outputs.

---
 rtl/prompt_sequencer.sv | 150 +++++++++++++++
 tb/tb_prompt_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/prompt_sequencer.sv
// Stores a growing LFSR-generated prompt sequence and replays it at a fixed show/gap cadence.
// Latency: requests act on the next edge; outputs decode from registered state; no backpressure.
module prompt_sequencer #(
  parameter int         MAX_LEN  = 16,
  parameter int         TICK_DIV = 25000000,
  parameter logic [7:0] SEED     = 8'hA5
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_append,
  input  logic       i_replay,
  input  logic       i_clear,
  output logic [2:0] o_prompt,
  output logic       o_busy,
  output logic       o_done,
  output logic [5:0] o_length,
  output logic       o_full
);

  localparam int             IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int             TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0]  TICK_LOAD = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0]  TICK_ONE  = TW'(1);
  localparam logic [IW-1:0]  IDX_ONE   = IW'(1);
  localparam logic [5:0]     LEN_MAX   = 6'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHOW,
    S_GAP,
    S_FIN
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_lfsr;
  logic [7:0]    w_lfsr_nxt;
  logic [TW-1:0] r_tick;
  logic [TW-1:0] w_tick_nxt;
  logic [IW-1:0] r_index;
  logic [IW-1:0] w_index_nxt;
  logic [5:0]    r_length;
  logic [5:0]    w_length_nxt;
  logic          w_wr_en;
  logic          w_full;
  logic          w_last;
  logic [1:0]    r_mem [MAX_LEN];

  assign w_full = (r_length == LEN_MAX);
  assign w_last = ({{(6-IW){1'b0}}, r_index} == (r_length - 6'd1));

  // Taps 8,6,5,4; an all-zero state (unreachable in practice) recovers to SEED.
  assign w_lfsr_nxt = (r_lfsr == 8'd0) ? SEED
                    : {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

  always_comb begin
    w_state_nxt  = r_state;
    w_tick_nxt   = r_tick;
    w_index_nxt  = r_index;
    w_length_nxt = r_length;
    w_wr_en      = 1'b0;
    if (i_clear) begin
      w_state_nxt  = S_IDLE;
      w_length_nxt = 6'd0;
      w_index_nxt  = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          // Append outranks replay; a simultaneous replay is dropped.
          if (i_append) begin
            if (!w_full) begin
              w_wr_en      = 1'b1;
              w_length_nxt = r_length + 6'd1;
            end
          end else if (i_replay) begin
            if (r_length != 6'd0) begin
              w_index_nxt = '0;
              w_tick_nxt  = TICK_LOAD;
              w_state_nxt = S_SHOW;
            end else begin
              w_state_nxt = S_FIN;
            end
          end
        end
        S_SHOW: begin
          if (r_tick == '0) begin
            w_tick_nxt  = TICK_LOAD;
            w_state_nxt = S_GAP;
          end else begin
            w_tick_nxt = r_tick - TICK_ONE;
          end
        end
        S_GAP: begin
          if (r_tick == '0) begin
            if (w_last) begin
              w_state_nxt = S_FIN;
            end else begin
              w_index_nxt = r_index + IDX_ONE;
              w_tick_nxt  = TICK_LOAD;
              w_state_nxt = S_SHOW;
            end
          end else begin
            w_tick_nxt = r_tick - TICK_ONE;
          end
        end
        S_FIN: begin
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= S_IDLE;
      r_lfsr   <= SEED;
      r_tick   <= '0;
      r_index  <= '0;
      r_length <= 6'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_lfsr   <= w_lfsr_nxt;
      r_tick   <= w_tick_nxt;
      r_index  <= w_index_nxt;
      r_length <= w_length_nxt;
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_wr_en) begin
      r_mem[r_length[IW-1:0]] <= r_lfsr[1:0];
    end
  end

  always_comb begin
    o_prompt = 3'd0;
    if (r_state == S_SHOW) begin
      o_prompt = {1'b0, r_mem[r_index]} + 3'd1;
    end
  end

  assign o_busy   = (r_state == S_SHOW) || (r_state == S_GAP);
  assign o_done   = (r_state == S_FIN);
  assign o_length = r_length;
  assign o_full   = w_full;

endmodule

// File: tb/tb_prompt_sequencer.sv
// Directed plus randomized bench for prompt_sequencer against a queue-based reference model.
module tb_prompt_sequencer;

  localparam int         T  = 4;
  localparam int         ML = 16;
  localparam logic [7:0] SD = 8'hA5;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic       append  = 1'b0;
  logic       replay  = 1'b0;
  logic       clear   = 1'b0;
  logic [2:0] prompt;
  logic       busy;
  logic       done;
  logic [5:0] length;
  logic       full;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] m_lfsr;
  logic [1:0] q[$];

  prompt_sequencer #(.MAX_LEN(ML), .TICK_DIV(T), .SEED(SD)) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .i_append (append),
    .i_replay (replay),
    .i_clear  (clear),
    .o_prompt (prompt),
    .o_busy   (busy),
    .o_done   (done),
    .o_length (length),
    .o_full   (full)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    if (v == 8'd0) return SD;
    return (v << 1) | 8'(^(v & 8'hB8));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= SD;
    else        m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, " prompt"}, prompt, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
  endtask

  task automatic len_chk(input string tag);
    chk({tag, " length"}, length, q.size());
    chk({tag, " full"}, full, (q.size() == ML) ? 1 : 0);
  endtask

  task automatic do_append(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      append = 1'b1;
      if (q.size() < ML) q.push_back(m_lfsr[1:0]);
      @(negedge clk);
    end
    append = 1'b0;
    len_chk(tag);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    q.delete();
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Each stored code occupies T show cycles then T blank cycles; done follows the last gap.
  task automatic do_replay(input string tag, input int mid);
    int         len;
    int         slot;
    logic [2:0] ep;
    logic       eb;
    logic       ed;
    len = q.size();
    replay = 1'b1;
    @(negedge clk);
    replay = 1'b0;
    for (int t = 1; t <= 2 * T * len + 1; t++) begin
      if (t > 1) @(negedge clk);
      if (t <= 2 * T * len) begin
        slot = (t - 1) / T;
        eb = 1'b1;
        ed = 1'b0;
        ep = (slot % 2 == 0) ? ({1'b0, q[slot/2]} + 3'd1) : 3'd0;
      end else begin
        eb = 1'b0;
        ed = 1'b1;
        ep = 3'd0;
      end
      chk($sformatf("%s prompt t=%0d", tag, t), prompt, ep);
      chk($sformatf("%s busy t=%0d", tag, t), busy, eb);
      chk($sformatf("%s done t=%0d", tag, t), done, ed);
      append = (t == mid);
    end
    append = 1'b0;
    @(negedge clk);
    idle_chk({tag, " after"});
    len_chk({tag, " after"});
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      idle_chk($sformatf("reset c%0d", i));
      len_chk($sformatf("reset c%0d", i));
    end

    do_append("append3", 3);
    do_replay("replay3", -1);

    do_clear();
    do_append("sat", 20);
    do_replay("sat", -1);

    do_clear();
    do_replay("empty", -1);
    do_append("two", 2);
    do_replay("midshow", 2);

    append = 1'b1;
    replay = 1'b1;
    q.push_back(m_lfsr[1:0]);
    @(negedge clk);
    append = 1'b0;
    replay = 1'b0;
    len_chk("simul");
    idle_chk("simul c1");
    @(negedge clk);
    idle_chk("simul c2");

    clear  = 1'b1;
    append = 1'b1;
    q.delete();
    @(negedge clk);
    clear  = 1'b0;
    append = 1'b0;
    len_chk("clr+app");

    do_append("gapclr", 2);
    replay = 1'b1;
    @(negedge clk);
    replay = 1'b0;
    repeat (5) @(negedge clk);
    chk("gapclr in gap busy", busy, 1);
    chk("gapclr in gap prompt", prompt, 0);
    do_clear();
    idle_chk("gapclr c1");
    len_chk("gapclr c1");
    repeat (3) begin
      @(negedge clk);
      idle_chk("gapclr later");
    end

    do_append("arst", 3);
    replay = 1'b1;
    @(negedge clk);
    replay = 1'b0;
    @(negedge clk);
    chk("arst in show busy", busy, 1);
    chk("arst in show prompt", prompt, {1'b0, q[0]} + 3'd1);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    idle_chk("arst async");
    len_chk("arst async");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    idle_chk("arst released");
    do_append("post-rst", 2);
    do_replay("post-rst", -1);

    for (int it = 0; it < 14; it++) begin
      op = $urandom_range(0, 5);
      if (op <= 2)      do_append($sformatf("rnd%0d app", it), $urandom_range(1, 5));
      else if (op <= 4) do_replay($sformatf("rnd%0d rep", it), $urandom_range(1, 4 * T));
      else begin
        do_clear();
        len_chk($sformatf("rnd%0d clr", it));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
